// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the sequencer and its LUT loader.
// Contents:
//   - sequencer state encodings
//   - LUT entry layout: field offsets and widths, plus a packed struct
//   - loader FSM state enum
package seq_pkg;

    localparam int unsigned LUT_W         = 37;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned ENTRY_BYTES   = 5;

    localparam int unsigned NEXT_STATE_LSB = 0;
    localparam int unsigned NEXT_STATE_W   = 3;
    localparam int unsigned REPEAT_LSB     = 3;
    localparam int unsigned REPEAT_W       = 8;
    localparam int unsigned LENGTH_LSB     = 11;
    localparam int unsigned LENGTH_W       = 16;
    localparam int unsigned EOF_BIT        = 27;
    localparam int unsigned SOF_BIT        = 28;
    localparam int unsigned NEXT_ADDR_LSB  = 29;
    localparam int unsigned NEXT_ADDR_W    = 8;

    // Sequencer state encodings, as stored in the next_state field.
    typedef enum logic [2:0] {
        SEQ_RST          = 3'd0,
        SEQ_IDLE         = 3'd1,
        SEQ_PANEL_STABLE = 3'd2,
        SEQ_CLEAR        = 3'd3,
        SEQ_INTEGRATE    = 3'd4,
        SEQ_SHIFT        = 3'd5,
        SEQ_WAIT         = 3'd6,
        SEQ_READOUT      = 3'd7
    } seq_state_t;

    // One LUT command entry. The first field listed is the MSB.
    typedef struct packed {
        logic [NEXT_ADDR_W-1:0] next_address;
        logic                   sof;
        logic                   eof;
        logic [LENGTH_W-1:0]    data_length;
        logic [REPEAT_W-1:0]    repeat_count;
        seq_state_t             next_state;
    } lut_entry_t;

    // Loader FSM states.
    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_COLLECT = 3'd1,
        LD_WRITE   = 3'd2,
        LD_SETTLE  = 3'd3,
        LD_VERIFY  = 3'd4,
        LD_FINISH  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/seq_lut_byte_packer.sv
// seq_lut_byte_packer: assembles five little-endian host bytes into one LUT entry.
// Ports:
//   clk, reset_i      - clock, synchronous active-high reset
//   i_clear           - restart assembly at byte 0
//   i_accept, i_byte  - byte handshake qualifier and data
//   o_last_c          - combinational: the byte accepted this cycle completes an entry
//   o_entry           - last completed entry (registered)
//   o_complete        - one-cycle flag: o_entry was updated on the previous edge
module seq_lut_byte_packer
    import seq_pkg::*;
#(
    parameter int unsigned LUT_WIDTH = 37
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [7:0]           i_byte,
    output logic                 o_last_c,
    output logic [LUT_WIDTH-1:0] o_entry,
    output logic                 o_complete
);

    localparam int unsigned LOW_W  = (ENTRY_BYTES - 1) * BYTE_W;
    localparam int unsigned HIGH_W = LUT_WIDTH - LOW_W;

    logic [LOW_W-1:0]     r_shift;
    logic [2:0]           r_cnt;
    logic [LUT_WIDTH-1:0] r_entry;
    logic                 r_complete;

    assign o_last_c   = i_accept && (r_cnt == 3'(ENTRY_BYTES - 1));
    assign o_entry    = r_entry;
    assign o_complete = r_complete;

    // Bytes 0..3 shift in from the top. Byte 4 supplies only the bits that fit the entry.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_entry    <= '0;
            r_complete <= 1'b0;
        end else if (i_clear) begin
            r_cnt      <= '0;
            r_complete <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            if (i_accept) begin
                if (o_last_c) begin
                    r_entry    <= {i_byte[HIGH_W-1:0], r_shift};
                    r_cnt      <= '0;
                    r_complete <= 1'b1;
                end else begin
                    r_shift <= {i_byte, r_shift[LOW_W-1:BYTE_W]};
                    r_cnt   <= r_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_lut_loader.sv
// seq_lut_loader: streams host bytes into LUT entries, writes them to the
// sequencer LUT, and owns the config_done handshake.
// Optional feature macro: SEQ_LUT_VERIFY_EN. When defined, the LUT is read back
// after the writes and the XOR-fold of the readback is checked.
// Ports:
//   clk, reset_i                  - clock, synchronous active-high reset
//   start_i, entry_count_i        - load request and entry count
//   host_valid_i, host_data_i,
//   host_ready_o                  - byte stream handshake
//   lut_wen_o, lut_write_data_o   - LUT write strobe and entry
//   lut_rden_o, lut_read_data_i   - LUT readback (verify build only)
//   config_done_o                 - low while the LUT is being configured or after a failed load
//   busy_o, done_o, error_o       - status
module seq_lut_loader
    import seq_pkg::*;
#(
    parameter int unsigned LUT_WIDTH     = 37,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] entry_count_i,
    input  logic                  host_valid_i,
    input  logic [7:0]            host_data_i,
    output logic                  host_ready_o,
    output logic                  lut_wen_o,
    output logic [LUT_WIDTH-1:0]  lut_write_data_o,
    output logic                  lut_rden_o,
    input  logic [LUT_WIDTH-1:0]  lut_read_data_i,
    output logic                  config_done_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    ld_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [SETTLE_W-1:0]   r_settle_cnt;
    logic                  r_host_ready;
    logic                  r_wen;
    logic                  r_config_done;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    ld_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_remaining_nxt;
    logic [SETTLE_W-1:0]   w_settle_nxt;
    logic                  w_ready_nxt;
    logic                  w_wen_nxt;
    logic                  w_config_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_error_nxt;
    logic                  w_clear;

    logic                  w_accept;
    logic                  w_last;
    logic [LUT_WIDTH-1:0]  w_entry;
    logic                  w_entry_valid;
    logic [ADDR_WIDTH-1:0] w_next_addr;

`ifdef SEQ_LUT_VERIFY_EN
    logic                    r_rden;
    logic [ADDR_WIDTH-1:0]   r_issued;
    logic [ADDR_WIDTH-1:0]   r_samples;
    logic [READ_LATENCY-1:0] r_rd_pipe;
    logic [LUT_WIDTH-1:0]    r_wr_fold;
    logic [LUT_WIDTH-1:0]    r_rd_fold;

    logic                    w_rden_nxt;
    logic [ADDR_WIDTH-1:0]   w_issued_nxt;
    logic [ADDR_WIDTH-1:0]   w_samples_nxt;
    logic [LUT_WIDTH-1:0]    w_wr_fold_nxt;
    logic [LUT_WIDTH-1:0]    w_rd_fold_nxt;

    assign lut_rden_o = r_rden;
`else
    logic w_unused_rd;

    assign lut_rden_o  = 1'b0;
    assign w_unused_rd = ^{lut_read_data_i, 32'(READ_LATENCY)};
`endif

    assign w_accept    = r_host_ready && host_valid_i;
    assign w_next_addr = w_entry[NEXT_ADDR_LSB +: ADDR_WIDTH];

    seq_lut_byte_packer #(
        .LUT_WIDTH (LUT_WIDTH)
    ) u_packer (
        .clk        (clk),
        .reset_i    (reset_i),
        .i_clear    (w_clear),
        .i_accept   (w_accept),
        .i_byte     (host_data_i),
        .o_last_c   (w_last),
        .o_entry    (w_entry),
        .o_complete (w_entry_valid)
    );

    assign host_ready_o     = r_host_ready;
    assign lut_wen_o        = r_wen;
    assign lut_write_data_o = w_entry;
    assign config_done_o    = r_config_done;
    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign error_o          = r_error;

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_remaining_nxt   = r_remaining;
        w_settle_nxt      = r_settle_cnt;
        w_ready_nxt       = 1'b0;
        w_wen_nxt         = 1'b0;
        w_done_nxt        = 1'b0;
        w_busy_nxt        = r_busy;
        w_config_done_nxt = r_config_done;
        w_error_nxt       = r_error;
        w_clear           = 1'b0;
`ifdef SEQ_LUT_VERIFY_EN
        w_rden_nxt        = 1'b0;
        w_issued_nxt      = r_issued;
        w_samples_nxt     = r_samples;
        w_wr_fold_nxt     = r_wr_fold;
        w_rd_fold_nxt     = r_rd_fold;
`endif

        unique case (r_state)
            LD_IDLE: begin
                if (start_i) begin
                    w_clear = 1'b1;
                    if (entry_count_i != '0) begin
                        w_count_nxt       = entry_count_i;
                        w_remaining_nxt   = entry_count_i;
                        w_error_nxt       = 1'b0;
                        w_config_done_nxt = 1'b0;
                        w_busy_nxt        = 1'b1;
                        w_ready_nxt       = 1'b1;
                        w_state_nxt       = LD_COLLECT;
`ifdef SEQ_LUT_VERIFY_EN
                        w_wr_fold_nxt     = '0;
`endif
                    end else begin
                        // An empty load only acknowledges; the LUT is left as it is.
                        w_done_nxt = 1'b1;
                    end
                end
            end

            LD_COLLECT: begin
                w_ready_nxt = 1'b1;
                if (w_last) begin
                    w_ready_nxt = 1'b0;
                    w_wen_nxt   = 1'b1;
                    w_state_nxt = LD_WRITE;
                end
            end

            LD_WRITE: begin
                // An out-of-range link is flagged, but the entry is still written.
                if (w_entry_valid && (w_next_addr >= r_count)) begin
                    w_error_nxt = 1'b1;
                end
`ifdef SEQ_LUT_VERIFY_EN
                if (w_entry_valid) begin
                    w_wr_fold_nxt = r_wr_fold ^ w_entry;
                end
`endif
                w_remaining_nxt = r_remaining - ADDR_WIDTH'(1);
                if (r_remaining != ADDR_WIDTH'(1)) begin
                    w_ready_nxt = 1'b1;
                    w_state_nxt = LD_COLLECT;
                end else begin
                    w_settle_nxt = '0;
                    w_state_nxt  = LD_SETTLE;
                end
            end

            LD_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
`ifdef SEQ_LUT_VERIFY_EN
                    w_rden_nxt    = 1'b1;
                    w_issued_nxt  = ADDR_WIDTH'(1);
                    w_samples_nxt = '0;
                    w_rd_fold_nxt = '0;
                    w_state_nxt   = LD_VERIFY;
`else
                    w_done_nxt        = 1'b1;
                    w_busy_nxt        = 1'b0;
                    w_config_done_nxt = !w_error_nxt;
                    w_state_nxt       = LD_FINISH;
`endif
                end else begin
                    w_settle_nxt = r_settle_cnt + SETTLE_W'(1);
                end
            end

`ifdef SEQ_LUT_VERIFY_EN
            LD_VERIFY: begin
                if (r_issued != r_count) begin
                    w_rden_nxt   = 1'b1;
                    w_issued_nxt = r_issued + ADDR_WIDTH'(1);
                end
                // Readback data arrives READ_LATENCY cycles behind each strobe.
                if (r_rd_pipe[READ_LATENCY-1]) begin
                    w_rd_fold_nxt = r_rd_fold ^ lut_read_data_i;
                    w_samples_nxt = r_samples + ADDR_WIDTH'(1);
                    if (r_samples == (r_count - ADDR_WIDTH'(1))) begin
                        if (w_rd_fold_nxt != r_wr_fold) begin
                            w_error_nxt = 1'b1;
                        end
                        w_done_nxt        = 1'b1;
                        w_busy_nxt        = 1'b0;
                        w_config_done_nxt = !w_error_nxt;
                        w_state_nxt       = LD_FINISH;
                    end
                end
            end
`endif

            LD_FINISH: begin
                w_state_nxt = LD_IDLE;
            end

            default: begin
                w_state_nxt = LD_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state       <= LD_IDLE;
            r_count       <= '0;
            r_remaining   <= '0;
            r_settle_cnt  <= '0;
            r_host_ready  <= 1'b0;
            r_wen         <= 1'b0;
            r_config_done <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef SEQ_LUT_VERIFY_EN
            r_rden        <= 1'b0;
            r_issued      <= '0;
            r_samples     <= '0;
            r_rd_pipe     <= '0;
            r_wr_fold     <= '0;
            r_rd_fold     <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_remaining   <= w_remaining_nxt;
            r_settle_cnt  <= w_settle_nxt;
            r_host_ready  <= w_ready_nxt;
            r_wen         <= w_wen_nxt;
            r_config_done <= w_config_done_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_error       <= w_error_nxt;
`ifdef SEQ_LUT_VERIFY_EN
            r_rden        <= w_rden_nxt;
            r_issued      <= w_issued_nxt;
            r_samples     <= w_samples_nxt;
            r_rd_pipe     <= (r_rd_pipe << 1) | READ_LATENCY'(r_rden);
            r_wr_fold     <= w_wr_fold_nxt;
            r_rd_fold     <= w_rd_fold_nxt;
`endif
        end
    end

endmodule

// File: doc/seq_lut_loader.md
# seq_lut_loader

Writer-side companion to `sequencer_fsm`. It takes a host byte stream, assembles 37-bit LUT command entries, and writes them into the sequencer LUT RAM. It owns the `config_done` handshake that gates sequencer execution. It sits between the host register/UART bridge and `sequencer_fsm`. Its `lut_*` outputs and `config_done_o` drive the sequencer's `lut_wen_i`, `lut_write_data_i`, `lut_rden_i` and `config_done_i`.

## Interface
- `LUT_WIDTH`, 37: LUT entry width.
- `ADDR_WIDTH`, 8: LUT address and next-address field width.
- `SETTLE_CYCLES`, 2: idle cycles between the last write and the release of `config_done_o`, minimum 1.
- `READ_LATENCY`, 1: cycles from `lut_rden_o` to valid `lut_read_data_i`.
- `clk` input 1: the single clock.
- `reset_i` input 1: synchronous, active-high reset.
- `start_i` input 1: single-cycle pulse that begins a load. Ignored while `busy_o` is high.
- `entry_count_i` input ADDR_WIDTH: number of entries to load. Sampled on `start_i`.
- `host_valid_i` input 1: `host_data_i` is valid.
- `host_data_i` input 8: entry byte, little-endian.
- `host_ready_o` output 1: loader accepts a byte this cycle.
- `lut_wen_o` output 1: LUT write strobe.
- `lut_write_data_o` output LUT_WIDTH: packed entry.
- `lut_rden_o` output 1: LUT read strobe (verify only).
- `lut_read_data_i` input LUT_WIDTH: LUT readback (verify only).
- `config_done_o` output 1: low while the LUT is being configured.
- `busy_o` output 1: load in progress.
- `done_o` output 1: one-cycle pulse at the end of a load.
- `error_o` output 1: sticky error flag. Cleared on `start_i`.

## Operation
- Reset values:
  - `config_done_o` = 1.
  - `host_ready_o`, `lut_wen_o`, `lut_rden_o`, `busy_o`, `done_o`, `error_o` = 0.
  - `lut_write_data_o` = 0.
  - FSM returns to IDLE.
- Entry layout: [2:0] next_state, [10:3] repeat_count, [26:11] data_length, [27] eof, [28] sof, [36:29] next_address.
- Byte packing: byte0 → bits [7:0], through byte4 → bits [36:32]. Bits [7:5] of byte4 are discarded.
- FSM states: IDLE → COLLECT → WRITE → (COLLECT | SETTLE) → [VERIFY] → FINISH → IDLE.
- IDLE:
  - On `start_i` with `entry_count_i` ≠ 0: latch the count, clear `error_o`, drive `config_done_o` low, drive `busy_o` high, enter COLLECT.
  - On `start_i` with `entry_count_i` = 0: pulse `done_o` only. No writes, `config_done_o` unchanged.
- COLLECT: `host_ready_o` = 1. A byte is accepted when valid and ready are both high. When the 5th byte is accepted, enter WRITE.
- WRITE:
  - `lut_wen_o` = 1 for exactly one cycle, with the assembled entry. `host_ready_o` = 0.
  - The sequencer auto-increments its write address from 0 while `config_done_i` is low, so the loader carries no address.
  - Range check: next_address ≥ latched count sets `error_o`. The write still occurs.
  - Go to COLLECT if entries remain, otherwise SETTLE.
- SETTLE: hold all strobes low for SETTLE_CYCLES.
- FINISH:
  - Drive `config_done_o` high unless `error_o` is set. On error, `config_done_o` stays low.
  - Pulse `done_o`, drop `busy_o`.
- Reset mid-load: immediate return to IDLE with reset values. The partially written LUT contents are undefined, and the host must reload.
- `start_i` together with `reset_i`: reset wins.

## Timing
- A byte is accepted on the rising edge where `host_valid_i` and `host_ready_o` are both high.
- `lut_wen_o` rises on the cycle after the 5th-byte handshake.
- Minimum cost is 6 cycles per entry: 5 handshakes plus 1 write.
- `config_done_o` rises SETTLE_CYCLES+1 cycles after the last `lut_wen_o`, coincident with `done_o`.
- `host_data_i` is ignored outside COLLECT.

## Configuration
- `SEQ_LUT_VERIFY_EN` defined:
  - After SETTLE, VERIFY issues `lut_rden_o` on `count` consecutive cycles. The sequencer read address auto-increments from 0 while `config_done_i` is low.
  - Each readback is sampled READ_LATENCY cycles after its strobe and XOR-folded.
  - The result is compared against the XOR-fold of the written entries. On mismatch, set `error_o`, which keeps `config_done_o` low.
  - FINISH follows the last sample.
- `SEQ_LUT_VERIFY_EN` not defined: VERIFY is removed, `lut_rden_o` is tied 0, and `lut_read_data_i` is unused.

## Structure
- Shared package `seq_pkg`:
  - the sequencer state encodings (RST=0 … READOUT=7);
  - the packed LUT entry struct;
  - field offset and width constants;
  - the loader FSM enum.
- Sub-module `seq_lut_byte_packer`: 5-byte shift/assembly register with a byte counter and an entry-complete flag.

## Test plan
- Load 3 entries, bytes streamed back-to-back: entry 0 = PANEL_STABLE, repeat 0, length 5, next_addr 1.
  - Expect exactly 3 `lut_wen_o` pulses, 6 cycles apart.
  - Expect `lut_write_data_o` = 0x0_2000_2802 for entry 0.
  - Expect `config_done_o` high 3 cycles after the last write, and one `done_o` pulse.
- `host_valid_i` toggles every other cycle: expect identical write data, with each write 1 cycle after the 5th accepted byte.
- Entry with next_address 9 when count = 4: `error_o` = 1, all 4 writes occur, and `config_done_o` stays 0 after `done_o`.
- `reset_i` asserted after the 7th byte: the next cycle shows `config_done_o` = 1 and `busy_o` = 0, with no further `lut_wen_o`.
- `start_i` with count 0, and `start_i` while busy: count 0 gives a single `done_o` pulse with no writes; `start_i` while busy is ignored.
- With `SEQ_LUT_VERIFY_EN`, a model RAM corrupts entry 1 on readback: `error_o` = 1 and `config_done_o` stays 0. With clean RAM: `error_o` = 0.
